// File: rtl/alu_seq_if.sv
// Operand/result bundle between the datapath controller (master) and alu_seq (slave).
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       Opcode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [4:0]       Flags;
  logic             busy;
  logic             done;

  modport master (output start, Opcode, A, B, input C, Flags, busy, done);
  modport slave  (input start, Opcode, A, B, output C, Flags, busy, done);
endinterface

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle logic/arith/compare/shift ops plus an optional
// iterative shift-add multiply; result and sticky flags behind start/busy/done.
module alu_seq #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_CMP  = 4'b1011;
  localparam logic [3:0] OP_CMPU = 4'b1000;
  localparam logic [3:0] OP_LSH  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1101;

  localparam int FL_C = 0;
  localparam int FL_L = 1;
  localparam int FL_F = 2;
  localparam int FL_Z = 3;
  localparam int FL_N = 4;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [4:0]       flags_q, flags_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;
  logic [WIDTH-1:0] b_neg;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] shl_res;
  logic [WIDTH-1:0] shr_res;
  logic [WIDTH-1:0] step_sum;

  assign add_sum  = {1'b0, bus.A} + {1'b0, bus.B};
  assign sub_diff = {1'b0, bus.A} - {1'b0, bus.B};
  assign b_neg    = ~bus.B + WIDTH'(1);
  assign add_ovf  = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (add_sum[WIDTH-1] != bus.A[WIDTH-1]);
  assign sub_ovf  = (bus.A[WIDTH-1] == b_neg[WIDTH-1]) && (sub_diff[WIDTH-1] != bus.A[WIDTH-1]);
  // Shift amounts of WIDTH or more naturally yield zero; b_neg is |B| when B<0.
  assign shl_res  = bus.A << bus.B;
  assign shr_res  = bus.A >> b_neg;
  assign step_sum = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    c_d      = c_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    if (state_q == ST_MUL) begin
      prod_d   = step_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) begin
        c_d     = step_sum;
        done_d  = 1'b1;
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end else if (bus.start) begin
      done_d = 1'b1;
      case (bus.Opcode)
        OP_AND: c_d = bus.A & bus.B;
        OP_OR:  c_d = bus.A | bus.B;
        OP_XOR: c_d = bus.A ^ bus.B;
        OP_ADD: begin
          c_d           = add_sum[WIDTH-1:0];
          flags_d[FL_C] = add_sum[WIDTH];
          flags_d[FL_F] = add_ovf;
        end
        OP_SUB: begin
          c_d           = sub_diff[WIDTH-1:0];
          flags_d[FL_C] = sub_diff[WIDTH];
          flags_d[FL_F] = sub_ovf;
        end
        OP_CMP: begin
          flags_d[FL_Z] = (bus.A == bus.B);
          flags_d[FL_N] = ($signed(bus.A) < $signed(bus.B));
          flags_d[FL_L] = sub_diff[WIDTH];
        end
        OP_CMPU: begin
          flags_d[FL_Z] = (bus.A == bus.B);
          flags_d[FL_L] = sub_diff[WIDTH];
        end
        OP_LSH: c_d = bus.B[WIDTH-1] ? shr_res : shl_res;
        OP_MUL: begin
          if (MUL_EN) begin
            done_d   = 1'b0;
            state_d  = ST_MUL;
            cnt_d    = '0;
            prod_d   = '0;
            mcand_d  = bus.A;
            mplier_d = bus.B;
          end else begin
            c_d = '0;
          end
        end
        default: c_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      c_q      <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      c_q      <= c_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  assign bus.C     = c_q;
  assign bus.Flags = flags_q;
  assign bus.done  = done_q;
  assign bus.busy  = (state_q == ST_MUL);
endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 16;

  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_CMP  = 4'b1011;
  localparam logic [3:0] OP_CMPU = 4'b1000;
  localparam logic [3:0] OP_LSH  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1101;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_c;
  logic [4:0]   exp_flags;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int to_signed(input logic [W-1:0] v);
    return v[W-1] ? int'(v) - (1 << W) : int'(v);
  endfunction

  // Reference: updates the expected C and Flags from the operation's arithmetic meaning.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint r;
    int sa = to_signed(a);
    int sb = to_signed(b);
    logic [W-1:0] bp;
    case (op)
      OP_AND: exp_c = a & b;
      OP_OR:  exp_c = a | b;
      OP_XOR: exp_c = a ^ b;
      OP_ADD: begin
        r = ua + ub;
        exp_c = W'(r);
        exp_flags[0] = (r >= (64'sd1 << W));
        exp_flags[2] = (a[W-1] == b[W-1]) && (exp_c[W-1] != a[W-1]);
      end
      OP_SUB: begin
        exp_c = W'(ua - ub);
        bp = W'(-ub);
        exp_flags[0] = (ua < ub);
        exp_flags[2] = (a[W-1] == bp[W-1]) && (exp_c[W-1] != a[W-1]);
      end
      OP_CMP: begin
        exp_flags[3] = (ua == ub);
        exp_flags[4] = (sa < sb);
        exp_flags[1] = (ua < ub);
      end
      OP_CMPU: begin
        exp_flags[3] = (ua == ub);
        exp_flags[1] = (ua < ub);
      end
      OP_LSH: begin
        if (sb >= 0) exp_c = (sb >= W) ? '0 : W'(ua << sb);
        else         exp_c = (-sb >= W) ? '0 : W'(ua >> (-sb));
      end
      OP_MUL: exp_c = W'(ua * ub);
      default: exp_c = '0;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_c = '0;
    exp_flags = '0;
    check("rst_C", 32'(bus.C), 32'(exp_c));
    check("rst_Flags", 32'(bus.Flags), 32'(exp_flags));
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    $display("reset -> C=%h Flags=%b busy=%b done=%b", bus.C, bus.Flags, bus.busy, bus.done);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    check("idle_done", 32'(bus.done), 32'd0);
    check("idle_C", 32'(bus.C), 32'(exp_c));
  endtask

  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] prev_c = exp_c;
    @(negedge clk);
    bus.start = 1'b1; bus.Opcode = op; bus.A = a; bus.B = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    model(op, a, b);
    if (op == OP_MUL) begin
      check("mul_busy", 32'(bus.busy), 32'd1);
      check("mul_done_early", 32'(bus.done), 32'd0);
      for (int k = 1; k < W; k++) begin
        if (k == 3) begin
          // A start during busy must be dropped without a trace.
          @(negedge clk);
          bus.start = 1'b1; bus.Opcode = OP_AND; bus.A = W'($urandom); bus.B = W'($urandom);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("mul_busy", 32'(bus.busy), 32'd1);
        check("mul_done_early", 32'(bus.done), 32'd0);
        check("mul_C_hold", 32'(bus.C), 32'(prev_c));
      end
      @(posedge clk);
      #1;
      check("mul_busy_end", 32'(bus.busy), 32'd0);
    end else begin
      check("busy", 32'(bus.busy), 32'd0);
    end
    check("done", 32'(bus.done), 32'd1);
    check("C", 32'(bus.C), 32'(exp_c));
    check("Flags", 32'(bus.Flags), 32'(exp_flags));
    $display("op=%b A=%h B=%h -> C=%h Flags=%b", op, a, b, bus.C, bus.Flags);
  endtask

  task automatic mul_with_reset();
    @(negedge clk);
    bus.start = 1'b1; bus.Opcode = OP_MUL; bus.A = 16'h00FF; bus.B = 16'h00FF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    do_reset();
    for (int k = 0; k < W + 2; k++) begin
      @(posedge clk);
      #1;
      check("post_rst_done", 32'(bus.done), 32'd0);
      check("post_rst_busy", 32'(bus.busy), 32'd0);
    end
    check("post_rst_C", 32'(bus.C), 32'd0);
  endtask

  initial begin
    logic [3:0]   op;
    logic [W-1:0] a, b;
    int s;
    reset = 1'b1;
    bus.start = 1'b0; bus.Opcode = '0; bus.A = '0; bus.B = '0;
    exp_c = '0;
    exp_flags = '0;
    do_reset();

    do_op(OP_ADD, 16'h7FFF, 16'h0001);
    check("ovf_F", 32'(bus.Flags[2]), 32'd1);
    idle_cycle();
    do_op(OP_ADD, 16'hFFFF, 16'h0001);
    check("carry_C", 32'(bus.Flags[0]), 32'd1);
    do_op(OP_CMPU, 16'h0000, 16'hFFFF);
    do_op(OP_CMP, 16'h0000, 16'hFFFF);
    do_op(OP_CMP, 16'hFFFF, 16'hFFFF);
    idle_cycle();
    do_op(OP_MUL, 16'h0012, 16'h0034);
    check("mul_value", 32'(bus.C), 32'h03A8);
    idle_cycle();
    mul_with_reset();
    do_op(OP_AND, 16'hF0F0, 16'hFF00);
    do_op(OP_LSH, 16'h0001, 16'h0004);
    do_op(OP_LSH, 16'h0010, 16'hFFFC);
    do_op(OP_LSH, 16'hFFFF, 16'h0010);
    do_op(OP_SUB, 16'h0003, 16'h0005);
    do_op(OP_SUB, 16'h8000, 16'h0001);
    do_op(4'b1111, 16'h1234, 16'h5678);
    idle_cycle();

    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 15));
      a = W'($urandom);
      b = W'($urandom);
      if (op == OP_LSH && $urandom_range(0, 1) == 1) begin
        s = int'($urandom_range(0, 40));
        b = W'(s - 20);
      end
      if ((op == OP_CMP || op == OP_CMPU) && $urandom_range(0, 3) == 0) b = a;
      do_op(op, a, b);
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Registered, parametrised successor to the team's combinational 16-bit ALU. It captures operands on a start pulse and executes single-cycle ops in one clock. It runs an optional iterative shift-add multiply over WIDTH clocks. Results and a persistent 5-bit flags register sit behind a start/busy/done handshake, so the datapath controller can issue ops back-to-back.

Parameters:
WIDTH, 16, operand/result width in bits (>=4)
MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL treated as undefined opcode

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
Opcode  input  4  operation select, captured with start
A  input  WIDTH  operand A, captured with start
B  input  WIDTH  operand B, captured with start
C  output  WIDTH  registered result
Flags  output  5  registered flags: [0]=C carry, [1]=L unsigned-less, [2]=F signed overflow, [3]=Z zero/equal, [4]=N signed-less
busy  output  1  high while multiply iterates
done  output  1  one-cycle pulse when C/Flags hold a new completed op

Behaviour:
- Reset (synchronous, takes priority over everything, including a MUL in progress): C=0, Flags=0, busy=0, done=0, iteration counter=0.
- Accept: start=1 and busy=0 at a rising edge. start while busy=1 is ignored, with no queuing.
- done defaults to 0 every cycle and is set only on completion. An accept in the cycle where done=1 is legal, so back-to-back single-cycle ops give done high on consecutive cycles.
- Single-cycle ops: C/Flags are updated at the accepting edge; done=1 for the following cycle (latency 1).
- Opcodes:
  - 0001 AND, 0010 OR, 0011 XOR: C=A op B; Flags unchanged.
  - 0101 ADD: C=A+B mod 2^WIDTH; carry=carry-out; F=signed overflow; L, Z, N unchanged.
  - 1001 SUB: C=A-B; carry=borrow (A<B unsigned); F=signed overflow; L, Z, N unchanged.
  - 1011 CMP: C unchanged; Z=(A==B); N=($signed(A)<$signed(B)); L=(A<B unsigned); carry and F unchanged.
  - 1000 CMPU: C unchanged; Z=(A==B); L=(A<B unsigned); carry, F, N unchanged.
  - 1100 LSH: B is a signed shift amount. B>=0: C=A<<B. B<0: C=A>>(-B), logical. |B|>=WIDTH gives C=0. Flags unchanged.
  - 1101 MUL (MUL_EN=1): low WIDTH bits of A*B, unsigned.
  - Any other opcode: C=0, Flags unchanged, done pulses at latency 1.
- MUL state machine, states IDLE and MUL:
  - IDLE -> MUL at accept: busy<=1, counter<=0, partial product<=0, multiplier/multiplicand registered.
  - In MUL, each edge processes one multiplier bit (LSB first) and increments counter.
  - At the edge where counter reaches WIDTH-1 the final step completes: C<=product[WIDTH-1:0], busy<=0, done<=1, state returns to IDLE.
  - Total: done visible WIDTH edges after the accepting edge.
  - Flags unchanged by MUL.
  - C holds its previous value while busy=1.
- Arithmetic: all internal sums are WIDTH+1 bits. Overflow F = (A[msb]==B'[msb]) && (R[msb]!=A[msb]), where B' = B for ADD and ~B+1 for SUB.
- Flags bits not written by an op hold their value indefinitely. There is no clear other than reset.

Test Plan:
- Assert reset for 2 cycles mid-run, then deassert -> C=0x0000, Flags=5'b00000, busy=0, done=0.
- ADD A=0x7FFF, B=0x0001 -> next cycle C=0x8000, Flags[2]=1, Flags[0]=0, done=1 for exactly one cycle. Then ADD A=0xFFFF, B=0x0001 -> C=0x0000, Flags[0]=1, Flags[2]=0.
- CMPU A=0x0000, B=0xFFFF -> Flags[1]=1, Flags[3]=0, C unchanged. Then CMP A=0x0000, B=0xFFFF -> Flags[4]=0, Flags[1]=1. Then CMP A=0xFFFF, B=0xFFFF -> Flags[3]=1, Flags[4]=0, Flags[1]=0.
- MUL A=0x0012, B=0x0034 -> busy=1 for 16 cycles; C=0x03A8 and done=1 exactly 16 edges after accept. A start of AND issued during busy produces no extra done and does not alter C.
- Reset asserted at iteration 7 of MUL A=0x00FF, B=0x00FF -> busy=0, C=0, no done pulse afterward. A following AND A=0xF0F0, B=0xFF00 -> C=0xF000 at latency 1.
- LSH A=0x0001, B=0x0004 -> C=0x0010. LSH A=0x0010, B=0xFFFC -> C=0x0001. LSH A=0xFFFF, B=0x0010 -> C=0x0000. Opcode 1111 -> C=0x0000, Flags unchanged, done=1.
